// File: rtl/ga_defs_pkg.sv
// Shared GA definitions: default widths, FSM encoding and LFSR constants.
package ga_defs_pkg;

  localparam int unsigned SELF_FIT_LENGTH_DEF = 10;
  localparam int unsigned IDX_WIDTH_DEF       = 8;
  localparam int unsigned LFSR_W              = 16;

  localparam logic [LFSR_W-1:0] LFSR_MASK         = 16'hB400;
  localparam logic [LFSR_W-1:0] LFSR_DEFAULT_SEED = 16'hACE1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_SEL_A,
    ST_SEL_B,
    ST_CMP,
    ST_OUT,
    ST_DONE
  } sel_state_e;

  // One step of the right-shifting Galois LFSR.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] v);
    return (v >> 1) ^ (v[0] ? LFSR_MASK : '0);
  endfunction

endpackage

// File: rtl/ga_lfsr16.sv
// 16-bit Galois LFSR with seed load; a zero seed falls back to the default seed.
module ga_lfsr16
  import ga_defs_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_n,
  input  logic              load,
  input  logic [LFSR_W-1:0] seed,
  input  logic              step,
  output logic [LFSR_W-1:0] value
);

  logic [LFSR_W-1:0] value_q, value_d;

  // Next LFSR value: load has priority over stepping.
  always_comb begin
    value_d = value_q;
    if (load) begin
      value_d = (seed == '0) ? LFSR_DEFAULT_SEED : seed;
    end else if (step) begin
      value_d = lfsr_next(value_q);
    end
  end

  // LFSR state register.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) value_q <= LFSR_DEFAULT_SEED;
    else        value_q <= value_d;
  end

  assign value = value_q;

endmodule

// File: rtl/tournament_select.sv
// Fitness capture, elite tracking and binary-tournament parent selection.
module tournament_select
  import ga_defs_pkg::*;
#(
  parameter int unsigned SELF_FIT_LENGTH   = SELF_FIT_LENGTH_DEF,
  parameter int unsigned LATTICE_LENGTH    = 11,
  parameter int unsigned PARTICLE_LENGTH   = 2,
  parameter int unsigned INDIVIDUAL_LENGTH = LATTICE_LENGTH * PARTICLE_LENGTH,
  parameter int unsigned POP_SIZE          = 50,
  parameter int unsigned IDX_WIDTH         = IDX_WIDTH_DEF
) (
  input  logic                         clk_i,
  input  logic                         rst_n,
  input  logic                         gen_start_i,
  input  logic                         seed_load_i,
  input  logic [LFSR_W-1:0]            seed_i,
  input  logic                         in_valid_i,
  input  logic [SELF_FIT_LENGTH-1:0]   fitness_i,
  input  logic [INDIVIDUAL_LENGTH-1:0] individual_vec_i,
  input  logic [IDX_WIDTH-1:0]         ind_idx_i,
  input  logic                         parent_ready_i,
  output logic                         parent_valid_ff_o,
  output logic [IDX_WIDTH-1:0]         parent_idx_ff_o,
  output logic [SELF_FIT_LENGTH-1:0]   best_energy_ff_o,
  output logic [INDIVIDUAL_LENGTH-1:0] best_individual_ff_o,
  output logic [IDX_WIDTH-1:0]         best_idx_ff_o,
  output logic                         select_done_ff_o,
  output logic                         busy_ff_o
);

  localparam int unsigned CNT_W  = IDX_WIDTH + 1;
  localparam int unsigned SLOT_W = (POP_SIZE > 1) ? $clog2(POP_SIZE) : 1;
  localparam logic [CNT_W-1:0] POP_CNT = CNT_W'(POP_SIZE);

  sel_state_e state_q, state_d;
  logic [SELF_FIT_LENGTH-1:0]   fit_rf_q [POP_SIZE];
  logic [SELF_FIT_LENGTH-1:0]   fit_rf_d [POP_SIZE];
  logic [POP_SIZE-1:0]          slot_vld_q, slot_vld_d;
  logic [CNT_W-1:0]             recv_cnt_q, recv_cnt_d;
  logic [CNT_W-1:0]             parent_cnt_q, parent_cnt_d;
  logic [IDX_WIDTH-1:0]         cand_a_q, cand_a_d;
  logic [IDX_WIDTH-1:0]         cand_b_q, cand_b_d;
  logic                         parent_valid_q, parent_valid_d;
  logic [IDX_WIDTH-1:0]         parent_idx_q, parent_idx_d;
  logic [SELF_FIT_LENGTH-1:0]   best_energy_q, best_energy_d;
  logic [INDIVIDUAL_LENGTH-1:0] best_ind_q, best_ind_d;
  logic [IDX_WIDTH-1:0]         best_idx_q, best_idx_d;
  logic                         select_done_q, select_done_d;
  logic                         busy_q, busy_d;

  logic [LFSR_W-1:0]    lfsr_val_c;
  logic [IDX_WIDTH-1:0] cand_c;
  logic                 cand_ok_c;
  logic                 wr_ok_c;
  logic [SLOT_W-1:0]    slot_c;
  logic                 lfsr_load_c;
  logic                 lfsr_step_c;
  logic                 unused_lfsr_c;

  // Random source for candidate draws; advances only while drawing.
  assign lfsr_load_c = (state_q == ST_IDLE) && seed_load_i;
  assign lfsr_step_c = (state_q == ST_SEL_A) || (state_q == ST_SEL_B);

  ga_lfsr16 u_lfsr (
    .clk_i (clk_i),
    .rst_n (rst_n),
    .load  (lfsr_load_c),
    .seed  (seed_i),
    .step  (lfsr_step_c),
    .value (lfsr_val_c)
  );

  assign cand_c        = lfsr_val_c[IDX_WIDTH-1:0];
  assign unused_lfsr_c = ^lfsr_val_c[LFSR_W-1:IDX_WIDTH];
  assign cand_ok_c     = {1'b0, cand_c} < POP_CNT;
  assign wr_ok_c       = (state_q == ST_COLLECT) && in_valid_i && ({1'b0, ind_idx_i} < POP_CNT);
  assign slot_c        = SLOT_W'(ind_idx_i);

  // Next-state, register-file, elite and handshake logic.
  always_comb begin
    state_d        = state_q;
    fit_rf_d       = fit_rf_q;
    slot_vld_d     = slot_vld_q;
    recv_cnt_d     = recv_cnt_q;
    parent_cnt_d   = parent_cnt_q;
    cand_a_d       = cand_a_q;
    cand_b_d       = cand_b_q;
    parent_valid_d = parent_valid_q;
    parent_idx_d   = parent_idx_q;
    best_energy_d  = best_energy_q;
    best_ind_d     = best_ind_q;
    best_idx_d     = best_idx_q;
    select_done_d  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (gen_start_i) begin
          slot_vld_d    = '0;
          recv_cnt_d    = '0;
          parent_cnt_d  = '0;
          best_energy_d = '1;
          best_ind_d    = '0;
          best_idx_d    = '0;
          state_d       = ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        if (wr_ok_c) begin
          fit_rf_d[slot_c] = fitness_i;
          if (!slot_vld_q[slot_c]) begin
            slot_vld_d[slot_c] = 1'b1;
            recv_cnt_d         = recv_cnt_q + CNT_W'(1);
          end
          if (fitness_i < best_energy_q) begin
            best_energy_d = fitness_i;
            best_ind_d    = individual_vec_i;
            best_idx_d    = ind_idx_i;
          end
        end
        if (recv_cnt_q == POP_CNT) state_d = ST_SEL_A;
      end
      ST_SEL_A: begin
        if (cand_ok_c) begin
          cand_a_d = cand_c;
          state_d  = ST_SEL_B;
        end
      end
      ST_SEL_B: begin
        if (cand_ok_c) begin
          cand_b_d = cand_c;
          state_d  = ST_CMP;
        end
      end
      ST_CMP: begin
        // Strictly lower energy wins; ties go to the first candidate.
        parent_idx_d   = (fit_rf_q[SLOT_W'(cand_b_q)] < fit_rf_q[SLOT_W'(cand_a_q)]) ? cand_b_q : cand_a_q;
        parent_valid_d = 1'b1;
        state_d        = ST_OUT;
      end
      ST_OUT: begin
        if (parent_ready_i) begin
          parent_valid_d = 1'b0;
          parent_cnt_d   = parent_cnt_q + CNT_W'(1);
          if ((parent_cnt_q + CNT_W'(1)) == POP_CNT) begin
            state_d       = ST_DONE;
            select_done_d = 1'b1;
          end else begin
            state_d = ST_SEL_A;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and datapath registers.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      for (int unsigned i = 0; i < POP_SIZE; i++) fit_rf_q[i] <= '0;
      slot_vld_q     <= '0;
      recv_cnt_q     <= '0;
      parent_cnt_q   <= '0;
      cand_a_q       <= '0;
      cand_b_q       <= '0;
      parent_valid_q <= 1'b0;
      parent_idx_q   <= '0;
      best_energy_q  <= '0;
      best_ind_q     <= '0;
      best_idx_q     <= '0;
      select_done_q  <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      fit_rf_q       <= fit_rf_d;
      slot_vld_q     <= slot_vld_d;
      recv_cnt_q     <= recv_cnt_d;
      parent_cnt_q   <= parent_cnt_d;
      cand_a_q       <= cand_a_d;
      cand_b_q       <= cand_b_d;
      parent_valid_q <= parent_valid_d;
      parent_idx_q   <= parent_idx_d;
      best_energy_q  <= best_energy_d;
      best_ind_q     <= best_ind_d;
      best_idx_q     <= best_idx_d;
      select_done_q  <= select_done_d;
      busy_q         <= busy_d;
    end
  end

  assign parent_valid_ff_o    = parent_valid_q;
  assign parent_idx_ff_o      = parent_idx_q;
  assign best_energy_ff_o     = best_energy_q;
  assign best_individual_ff_o = best_ind_q;
  assign best_idx_ff_o        = best_idx_q;
  assign select_done_ff_o     = select_done_q;
  assign busy_ff_o            = busy_q;

endmodule

// File: tb/tb_tournament_select.sv
// Randomized scoreboard bench for tournament_select (POP_SIZE=50).
module tb_tournament_select;

  localparam int POP = 50;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        gen_start_i, seed_load_i, in_valid_i, parent_ready_i;
  logic [15:0] seed_i;
  logic [9:0]  fitness_i;
  logic [21:0] individual_vec_i;
  logic [7:0]  ind_idx_i;
  logic        parent_valid_ff_o, select_done_ff_o, busy_ff_o;
  logic [7:0]  parent_idx_ff_o, best_idx_ff_o;
  logic [9:0]  best_energy_ff_o;
  logic [21:0] best_individual_ff_o;

  tournament_select dut (
    .clk_i                (clk),
    .rst_n                (rst_n),
    .gen_start_i          (gen_start_i),
    .seed_load_i          (seed_load_i),
    .seed_i               (seed_i),
    .in_valid_i           (in_valid_i),
    .fitness_i            (fitness_i),
    .individual_vec_i     (individual_vec_i),
    .ind_idx_i            (ind_idx_i),
    .parent_ready_i       (parent_ready_i),
    .parent_valid_ff_o    (parent_valid_ff_o),
    .parent_idx_ff_o      (parent_idx_ff_o),
    .best_energy_ff_o     (best_energy_ff_o),
    .best_individual_ff_o (best_individual_ff_o),
    .best_idx_ff_o        (best_idx_ff_o),
    .select_done_ff_o     (select_done_ff_o),
    .busy_ff_o            (busy_ff_o)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_fail = 0;
  int          hs_cnt = 0;
  int          done_cnt = 0;
  int          exp_q[$];
  int          m_rf[POP];
  logic [15:0] m_lfsr;
  int          m_best, m_bidx;
  logic [21:0] m_bvec;
  int          perm[POP];
  bit          did_stall = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp_v, $time);
    end
  endtask

  function automatic int draw_cand();
    int c;
    do begin
      c = int'(m_lfsr & 16'h00FF);
      m_lfsr = (m_lfsr >> 1) ^ ((m_lfsr & 16'h1) != 0 ? 16'hB400 : 16'h0000);
    end while (c >= POP);
    return c;
  endfunction

  // Expected parent stream: POP tournaments from the model's LFSR.
  task automatic push_parents();
    int a, b;
    repeat (POP) begin
      a = draw_cand();
      b = draw_cand();
      exp_q.push_back((m_rf[b] < m_rf[a]) ? b : a);
    end
  endtask

  // Monitor: pops on each handshake and checks hold/drop behaviour of valid.
  task automatic monitor();
    bit         prev_stall = 0, prev_hs = 0;
    logic [7:0] prev_idx = '0;
    int         e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 0;
        prev_hs    = 0;
      end else begin
        if (prev_stall) begin
          chk("valid_hold", 32'(parent_valid_ff_o), 32'd1);
          chk("idx_hold", 32'(parent_idx_ff_o), 32'(prev_idx));
        end
        if (prev_hs) chk("valid_drop", 32'(parent_valid_ff_o), 32'd0);
        if (parent_valid_ff_o && parent_ready_i) begin
          if (exp_q.size() == 0) begin
            chk("parent_unexpected", 32'(parent_idx_ff_o), 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            chk("parent_idx", 32'(parent_idx_ff_o), 32'(e));
          end
          hs_cnt++;
        end
        if (select_done_ff_o) done_cnt++;
        prev_stall = parent_valid_ff_o && !parent_ready_i;
        prev_hs    = parent_valid_ff_o && parent_ready_i;
        prev_idx   = parent_idx_ff_o;
      end
    end
  endtask

  // Random backpressure, with one 10-cycle stall on the first offered parent.
  task automatic ready_drv();
    int  stall_left = 0;
    bit  force_one  = 0;
    forever begin
      @(posedge clk);
      #1;
      if (stall_left > 0) begin
        parent_ready_i = 1'b0;
        stall_left--;
        if (stall_left == 0) force_one = 1;
      end else if (!did_stall && parent_valid_ff_o) begin
        did_stall      = 1;
        stall_left     = 9;
        parent_ready_i = 1'b0;
      end else if (force_one) begin
        parent_ready_i = 1'b1;
        force_one      = 0;
      end else begin
        parent_ready_i = ($urandom_range(0, 3) != 0);
      end
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_valid"}, 32'(parent_valid_ff_o), 32'd0);
    chk({tag, "_pidx"},  32'(parent_idx_ff_o), 32'd0);
    chk({tag, "_benergy"}, 32'(best_energy_ff_o), 32'd0);
    chk({tag, "_bvec"},  32'(best_individual_ff_o), 32'd0);
    chk({tag, "_bidx"},  32'(best_idx_ff_o), 32'd0);
    chk({tag, "_done"},  32'(select_done_ff_o), 32'd0);
    chk({tag, "_busy"},  32'(busy_ff_o), 32'd0);
  endtask

  // One fitness writeback; the model is updated only when the DUT should accept it.
  task automatic wr(input int idx, input int fit, input logic [21:0] vec, input bit accepted);
    in_valid_i       = 1'b1;
    ind_idx_i        = 8'(idx);
    fitness_i        = 10'(fit);
    individual_vec_i = vec;
    if (accepted) begin
      m_rf[idx] = fit;
      if (fit < m_best) begin
        m_best = fit;
        m_bidx = idx;
        m_bvec = vec;
      end
    end
    @(posedge clk);
    #1;
    in_valid_i = 1'b0;
  endtask

  task automatic run_gen(input bit do_seed, input logic [15:0] seed, input int maxfit, input bit abort);
    int t, hs0, dn0, i;
    if (do_seed) begin
      seed_load_i = 1'b1;
      seed_i      = seed;
      @(posedge clk);
      #1;
      seed_load_i = 1'b0;
      m_lfsr = (seed == 16'h0) ? 16'hACE1 : seed;
    end
    wr(3, 0, 22'h3FFFFF, 0);
    gen_start_i = 1'b1;
    @(posedge clk);
    #1;
    gen_start_i = 1'b0;
    m_best = 1023;
    m_bidx = 0;
    m_bvec = '0;
    @(negedge clk);
    chk("start_benergy", 32'(best_energy_ff_o), 32'h3FF);
    chk("start_bidx", 32'(best_idx_ff_o), 32'd0);
    chk("start_busy", 32'(busy_ff_o), 32'd1);
    @(posedge clk);
    #1;
    for (i = 0; i < POP; i++) perm[i] = i;
    for (i = POP - 1; i > 0; i--) begin
      int j, tmp;
      j = $urandom_range(0, i);
      tmp = perm[i]; perm[i] = perm[j]; perm[j] = tmp;
    end
    for (i = 0; i < 25; i++) wr(perm[i], $urandom_range(0, maxfit), 22'($urandom), 1);
    wr(perm[0], $urandom_range(0, maxfit), 22'($urandom), 1);
    wr(60, 0, 22'h155555, 0);
    wr(255, 0, 22'h2AAAAA, 0);
    gen_start_i = 1'b1;
    @(posedge clk);
    #1;
    gen_start_i = 1'b0;
    for (i = 25; i < POP - 1; i++) wr(perm[i], $urandom_range(0, maxfit), 22'($urandom), 1);
    repeat (20) @(negedge clk);
    chk("no_early_select", 32'(parent_valid_ff_o), 32'd0);
    chk("mid_benergy", 32'(best_energy_ff_o), 32'(m_best));
    chk("mid_bidx", 32'(best_idx_ff_o), 32'(m_bidx));
    @(posedge clk);
    #1;
    hs0 = hs_cnt;
    dn0 = done_cnt;
    wr(perm[POP-1], $urandom_range(0, maxfit), 22'($urandom), 1);
    push_parents();
    if (abort) begin
      for (t = 0; t < 2000 && hs_cnt < hs0 + 5; t++) @(negedge clk);
      chk("abort_reach", 32'(hs_cnt >= hs0 + 5), 32'd1);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(negedge clk);
      check_zero("midrst");
      exp_q.delete();
      m_lfsr = 16'hACE1;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      return;
    end
    for (t = 0; t < 6000 && done_cnt == dn0; t++) @(negedge clk);
    chk("done_seen", 32'(done_cnt - dn0), 32'd1);
    repeat (4) @(negedge clk);
    chk("parent_count", 32'(hs_cnt - hs0), 32'(POP));
    chk("done_pulses", 32'(done_cnt - dn0), 32'd1);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    chk("end_busy", 32'(busy_ff_o), 32'd0);
    chk("best_energy", 32'(best_energy_ff_o), 32'(m_best));
    chk("best_idx", 32'(best_idx_ff_o), 32'(m_bidx));
    chk("best_vec", 32'(best_individual_ff_o), 32'(m_bvec));
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n            = 1'b0;
    gen_start_i      = 1'b0;
    seed_load_i      = 1'b0;
    seed_i           = '0;
    in_valid_i       = 1'b0;
    fitness_i        = '0;
    individual_vec_i = '0;
    ind_idx_i        = '0;
    parent_ready_i   = 1'b0;
    m_lfsr           = 16'hACE1;
    fork
      monitor();
      ready_drv();
    join_none
    repeat (3) @(negedge clk);
    check_zero("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_gen(1, 16'h0001, 1023, 0);
    run_gen(1, 16'h0000, 3, 0);
    run_gen(0, 16'h0000, 63, 1);
    run_gen(0, 16'h0000, 15, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
